// File: rtl/counter_sequencer.sv
// counter_sequencer: command-driven controller for a WIDTH-bit up/down counter.
// Accepts LOAD / UP / DOWN / HOLD commands and drives the counter's enable,
// load, direction and data pins. It reports completion, the final count and
// the wrap and abort status of the command that just finished.
// Optional feature macro: CNTSEQ_SATURATE_EN. When it is defined, a step that
// would wrap is suppressed and the command ends at the bound.
//
// Handshake: a command transfers on a rising edge where cmd_valid & cmd_ready.
// cmd_ready is high only in IDLE. cmd_op/cmd_arg are sampled once on that
// edge and ignored afterwards.
module counter_sequencer #(
  parameter int WIDTH  = 4,
  parameter int STEP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [STEP_W-1:0] cmd_arg,
  input  logic              abort,
  output logic              cnt_enable,
  output logic              cnt_load,
  output logic              cnt_up_down_n,
  output logic [WIDTH-1:0]  cnt_data,
  input  logic [WIDTH-1:0]  cnt_value,
  output logic              done,
  output logic [WIDTH-1:0]  result,
  output logic              wrapped,
  output logic              aborted,
  output logic [2:0]        dbg_state
);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_HOLD = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_RUN  = 3'd2,
    S_HOLD = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    data_q;
  logic                dir_q;
  logic [STEP_W-1:0]   rem_q;
  logic [WIDTH-1:0]    result_q;
  logic                wrapped_q;
  logic                aborted_q;

  logic accept;
  logic at_bound;
  logic step_req;
  logic wrap_hit;
  logic step_issue;
  logic sat_stop;

  assign accept   = cmd_valid && (state_q == S_IDLE);
  // The next step in the latched direction would cross the wrap boundary.
  assign at_bound = dir_q ? (cnt_value == {WIDTH{1'b1}}) : (cnt_value == '0);
  // A step is wanted on every RUN cycle that abort does not cancel.
  assign step_req = (state_q == S_RUN) && !abort;
  assign wrap_hit = step_req && at_bound;

`ifdef CNTSEQ_SATURATE_EN
  // Saturating build: the wrapping step is withheld and the command stops.
  assign step_issue = step_req && !at_bound;
  assign sat_stop   = wrap_hit;
`else
  // Wrapping build: every requested step goes out and the counter wraps.
  assign step_issue = step_req;
  assign sat_stop   = 1'b0;
`endif

  // Next-state and Moore-decoded counter controls (abort gates the RUN enable).
  always_comb begin
    state_d       = state_q;
    cmd_ready     = 1'b0;
    cnt_enable    = 1'b0;
    cnt_load      = 1'b0;
    cnt_up_down_n = 1'b0;
    cnt_data      = '0;
    done          = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (cmd_op == OP_LOAD)      state_d = S_LOAD;
          else if (cmd_arg == '0)     state_d = S_DONE;
          else if (cmd_op == OP_HOLD) state_d = S_HOLD;
          else                        state_d = S_RUN;
        end
      end
      S_LOAD: begin
        cnt_enable = 1'b1;
        cnt_load   = 1'b1;
        cnt_data   = data_q;
        state_d    = S_DONE;
      end
      S_RUN: begin
        cnt_enable    = step_issue;
        cnt_up_down_n = dir_q;
        if ((rem_q == STEP_W'(1)) || abort || sat_stop) state_d = S_DONE;
      end
      S_HOLD: begin
        if ((rem_q == STEP_W'(1)) || abort) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register, command latch, step counter and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      data_q    <= '0;
      dir_q     <= 1'b0;
      rem_q     <= '0;
      result_q  <= '0;
      wrapped_q <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        data_q    <= cmd_arg[WIDTH-1:0];
        dir_q     <= (cmd_op == OP_UP);
        rem_q     <= cmd_arg;
        wrapped_q <= 1'b0;
        aborted_q <= 1'b0;
      end
      if ((state_q == S_RUN) || (state_q == S_HOLD)) begin
        rem_q <= rem_q - STEP_W'(1);
        if (abort) aborted_q <= 1'b1;
      end
      if (wrap_hit) wrapped_q <= 1'b1;
      if (state_q == S_DONE) result_q <= cnt_value;
    end
  end

  assign result    = result_q;
  assign wrapped   = wrapped_q;
  assign aborted   = aborted_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer: directed and random commands against counter_sequencer
// driving a behavioural 4-bit counter. Expected values come from an
// arithmetic model of each command. CNTSEQ_SATURATE_EN selects the saturating
// expectations.
module tb_counter_sequencer;

  // ---------------- clock / reset / signals ----------------
  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_arg;
  logic       abort;
  logic       cnt_enable;
  logic       cnt_load;
  logic       cnt_up_down_n;
  logic [3:0] cnt_data;
  logic [3:0] cnt_value = 4'd0;
  logic       done;
  logic [3:0] result;
  logic       wrapped;
  logic       aborted;
  logic [2:0] dbg_state;

  int tests = 0;
  int fails = 0;
  int mv    = 0;        // model's view of the counter value
  logic       keep_valid = 1'b0;
  logic [7:0] pend_arg   = 8'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  counter_sequencer #(.WIDTH(4), .STEP_W(8)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .abort(abort),
    .cnt_enable(cnt_enable), .cnt_load(cnt_load), .cnt_up_down_n(cnt_up_down_n),
    .cnt_data(cnt_data), .cnt_value(cnt_value), .done(done), .result(result),
    .wrapped(wrapped), .aborted(aborted), .dbg_state(dbg_state)
  );

  // The counter being controlled; it has no reset of its own here.
  always @(posedge clk) begin
    if (cnt_enable) begin
      if (cnt_load)           cnt_value <= cnt_data;
      else if (cnt_up_down_n) cnt_value <= cnt_value + 4'd1;
      else                    cnt_value <= cnt_value - 4'd1;
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [3:0] res;
    logic       wrp;
    logic       abt;
    int         lat;
    int         steps;
    int         loads;
  } exp_t;

  // Outcome of one command from counter value v; k = RUN/HOLD cycle of abort (0 = none).
  function automatic exp_t model(input int v, input int op, input int arg, input int k);
    exp_t e;
    int eff;
    int h;
    e.res = 4'(v); e.wrp = 1'b0; e.abt = 1'b0; e.steps = 0; e.loads = 0; e.lat = 1;
    if (op == 0) begin
      e.res = 4'(arg); e.lat = 2; e.loads = 1;
    end else if (arg != 0) begin
      e.abt = (k != 0) && (k <= arg);
      eff   = e.abt ? k - 1 : arg;
      e.lat = (e.abt ? k : arg) + 1;
      if (op != 3) begin
        h = (op == 1) ? 15 - v : v;
`ifdef CNTSEQ_SATURATE_EN
        if (eff > h) begin
          e.steps = h; e.wrp = 1'b1; e.abt = 1'b0; e.lat = h + 2;
        end else begin
          e.steps = eff;
        end
`else
        e.steps = eff;
        e.wrp   = (eff > h);
`endif
        e.res = (op == 1) ? 4'(v + e.steps) : 4'(v - e.steps);
      end
    end
    return e;
  endfunction

  // ---------------- scoreboard check ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Follows one accepted command from the accept edge to the IDLE cycle after done.
  task automatic monitor(input int op, input int arg, input int k);
    exp_t e;
    int   c, steps, loads, bad;
    logic seen, wr, ab;
    e = model(mv, op, arg, k);
    @(posedge clk); #1;
    if (keep_valid) begin
      cmd_op = 2'd0; cmd_arg = pend_arg;
    end else begin
      cmd_valid = 1'b0; cmd_op = 2'($urandom_range(0, 3)); cmd_arg = 8'($urandom);
    end
    c = 0; steps = 0; loads = 0; bad = 0; seen = 1'b0; wr = 1'b0; ab = 1'b0;
    while (!seen && c < 400) begin
      @(negedge clk);
      c++;
      abort = (c == k);
      #1;
      if (cnt_enable && !cnt_load) steps++;
      if (cnt_load) loads++;
      if (cmd_ready) bad++;
      if (!cnt_load && cnt_data != 4'd0) bad++;
      if (cnt_enable && !cnt_load && (cnt_up_down_n != (op == 1))) bad++;
      if (done) begin seen = 1'b1; wr = wrapped; ab = aborted; end
    end
    abort = 1'b0;
    chk("done_seen", seen, 1);
    chk("latency", c, e.lat);
    chk("enable_steps", steps, e.steps);
    chk("load_cycles", loads, e.loads);
    chk("busy_controls", bad, 0);
    chk("wrapped", wr, e.wrp);
    chk("aborted", ab, e.abt);
    @(negedge clk); #1;
    chk("result", result, e.res);
    chk("counter", cnt_value, e.res);
    chk("ready_after", cmd_ready, 1);
    chk("done_pulse", done, 0);
    mv = e.res;
  endtask

  // Presents a command, waits (bounded) for acceptance, then follows it.
  task automatic issue(input int op, input int arg, input int k);
    int w;
    cmd_valid = 1'b1; cmd_op = 2'(op); cmd_arg = 8'(arg);
    w = 0;
    while (!cmd_ready && w < 50) begin
      @(negedge clk); #1; w++;
    end
    chk("accept_wait", cmd_ready, 1);
    monitor(op, arg, k);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_arg = 8'd0; abort = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_state", dbg_state, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_ctl", {cnt_enable, cnt_load, cnt_up_down_n, cnt_data}, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {wrapped, aborted}, 0);
    rst = 1'b0;
    mv = 0;

    issue(0, 8'h09, 0);          // LOAD 9
    issue(0, 8'hAD, 0);          // LOAD D (upper arg bits ignored)
    issue(1, 5, 0);              // UP 5 across the wrap
    issue(0, 3, 0);
    issue(2, 3, 0);              // DOWN 3 to zero
    issue(2, 1, 0);              // DOWN 1 from zero
    issue(0, 0, 0);
    issue(1, 10, 4);             // UP 10, abort on 4th RUN cycle
    issue(0, 7, 0);
    issue(3, 6, 0);              // HOLD 6
    issue(1, 0, 0);              // UP 0
    issue(3, 4, 2);              // HOLD aborted
    issue(2, 5, 6);              // abort lands in DONE and is ignored
    issue(0, 8'h0F, 0);
    issue(1, 1, 0);              // UP from the top bound
    issue(3, 255, 0);            // longest count

    // A command held valid while busy is taken only once IDLE returns.
    keep_valid = 1'b1; pend_arg = 8'h05;
    issue(3, 4, 0);
    keep_valid = 1'b0;
    monitor(0, 8'h05, 0);

    for (int i = 0; i < 30; i++) begin
      int op, arg, k;
      op  = $urandom_range(0, 3);
      if (op == 0)                        arg = $urandom_range(0, 255);
      else if ($urandom_range(0, 7) == 0) arg = 0;
      else                                arg = $urandom_range(1, 20);
      k = ($urandom_range(0, 3) == 0) ? $urandom_range(1, arg + 1) : 0;
      issue(op, arg, k);
    end

    // Reset mid-RUN: UP 8 from 0, reset sampled on the 3rd step edge.
    issue(0, 0, 0);
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_arg = 8'd8;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("midrst_state", dbg_state, 0);
    chk("midrst_ready", cmd_ready, 1);
    chk("midrst_ctl", {cnt_enable, cnt_load, cnt_up_down_n, cnt_data}, 0);
    chk("midrst_outs", {done, result, wrapped, aborted}, 0);
    chk("midrst_counter", cnt_value, 3);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("midrst_hold", cnt_value, 3);
    mv = 3;
    issue(2, 2, 0);              // normal operation resumes

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/counter_sequencer.md
# counter_sequencer

Command-driven controller for the 4-bit synchronous up/down counter. It accepts one command at a time over a valid/ready handshake: load a value, step up N times, step down N times, or hold N cycles. It drives the counter's enable, load, direction and data inputs, and reports completion, the final count, and wrap or saturation status. It sits between the host or test-control logic and the counter instance.

## Interface
- `WIDTH`, default 4: counter data width; must match the counter instance.
- `STEP_W`, default 8: width of the step/hold count in `cmd_arg`.
- `clk`, in, 1: single clock; all logic is on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `cmd_valid`, in, 1: a command is presented.
- `cmd_ready`, out, 1: block can accept a command.
- `cmd_op`, in, 2: 00 LOAD, 01 UP, 10 DOWN, 11 HOLD.
- `cmd_arg`, in, `STEP_W`: for LOAD, the value (low `WIDTH` bits); otherwise the cycle/step count N.
- `abort`, in, 1: terminates RUN or HOLD early.
- `cnt_enable`, out, 1: drives the counter's enable.
- `cnt_load`, out, 1: drives the counter's load.
- `cnt_up_down_n`, out, 1: drives the counter's direction (1 = up).
- `cnt_data`, out, `WIDTH`: drives the counter's load data.
- `cnt_value`, in, `WIDTH`: the counter's output, fed back.
- `done`, out, 1: one-cycle completion pulse.
- `result`, out, `WIDTH`: `cnt_value` captured on `done`; held until the next `done`.
- `wrapped`, out, 1: the last command crossed a wrap boundary (or, with saturation enabled, was stopped at a bound); valid with `done` and held.
- `aborted`, out, 1: the last command ended by `abort`; valid with `done` and held.

## Operation
- States: IDLE, LOAD, RUN, HOLD, DONE.
- `cmd_ready` = 1 only in IDLE. A command is accepted on a cycle with `cmd_valid & cmd_ready`.
- On accept, latch `op`, `arg` and direction.
  - `rem <= arg`.
  - Clear `wrapped` and `aborted`.
- IDLE transitions on accept:
  - LOAD → LOAD.
  - UP/DOWN with N≠0 → RUN.
  - HOLD with N≠0 → HOLD.
  - Any N=0 command → DONE directly; no counter activity.
- LOAD state (one cycle): `cnt_enable=1`, `cnt_load=1`, `cnt_data=arg[WIDTH-1:0]`; then → DONE.
- RUN state:
  - `cnt_enable = ~abort`, `cnt_load=0`, `cnt_up_down_n` = latched direction.
  - Each cycle `rem` decrements.
  - → DONE when `rem==1` or `abort`.
- HOLD state: all `cnt_*` controls 0. `rem` decrements; → DONE when `rem==1` or `abort`.
- Wrap detection in RUN, on a cycle where a step is issued:
  - UP with `cnt_value == 2^WIDTH-1`, or DOWN with `cnt_value == 0`, sets `wrapped` (sticky for the command).
- Abort:
  - In RUN/HOLD, sets `aborted`; no step is issued that cycle; → DONE.
  - Ignored in IDLE, LOAD and DONE.
- DONE state (one cycle): `done=1`, `result <= cnt_value`; then → IDLE.
- `cnt_data` = 0 outside LOAD. `cnt_up_down_n` = 0 outside RUN.
- `cmd_op`/`cmd_arg` changes after accept have no effect.

## Timing
- Reset values: state IDLE, `cmd_ready=1`, all `cnt_*` = 0, `done=0`, `result=0`, `wrapped=0`, `aborted=0`, `rem=0`.
- Reset in any state → IDLE on the next edge, discarding the command in flight. The counter holds its value because `cnt_enable` drops.
- Control outputs are Moore-decoded from registered state. The only combinational path is `abort` → `cnt_enable`.
- LOAD accepted at edge t:
  - LOAD state during cycle t+1.
  - DONE during t+2; `result` equals the loaded value.
  - `cmd_ready` high again at t+3.
- UP/DOWN with N accepted at t:
  - Exactly N enable cycles, t+1..t+N.
  - DONE at t+N+1; `cmd_ready` at t+N+2.
- N=0: DONE at t+1.
- HOLD has the same cycle counts as UP/DOWN, with enable low throughout.
- Back-to-back commands: minimum gap is one IDLE cycle after DONE.

## Configuration
- Macro `CNTSEQ_SATURATE_EN`.
- Defined: in RUN, a step that would wrap is not issued.
  - `cnt_enable=0` that cycle, `wrapped` is set, → DONE; remaining steps are discarded.
  - Count stops at 2^WIDTH-1 (up) or 0 (down).
- Undefined: steps wrap modulo 2^WIDTH and `wrapped` flags the crossing; all N steps execute.

## Test plan
- Reset, then LOAD 0x9 → after 2 cycles `done=1`, `result=9`, `wrapped=0`; `cnt_load` high for exactly 1 cycle.
- LOAD 0xD, then UP N=5:
  - Default → `result=0x2`, `wrapped=1`, exactly 5 `cnt_enable` cycles.
  - With `CNTSEQ_SATURATE_EN` → `result=0xF`, `wrapped=1`, 2 enable cycles.
- LOAD 0x3, then DOWN N=3 → `result=0`, `wrapped=0`. A following DOWN N=1 → `result=0xF` (default) or `0x0` with `wrapped=1` (saturate).
- UP N=10 from 0, `abort` asserted on the 4th RUN cycle → `result=3`, `aborted=1`, no enable in the abort cycle.
- HOLD N=6 from value 7 → `done` 7 cycles after accept, `result=7`, `cnt_enable` never high. UP N=0 → `done` next cycle, no enable.
- `rst` asserted mid-RUN (UP N=8, after 3 steps) → next cycle IDLE, `cmd_ready=1`, all outputs 0, counter holds 3. `cmd_valid` while busy is not accepted until IDLE.
